// File: rtl/fetch_decode_if.sv
// Fetch/decode bus: ROM port, branch flag, register-file control and start/done handshake.
// master = fetch_decode stage, slave = surrounding top level or testbench.
interface fetch_decode_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic [PC_W-1:0] inst_addr;
    logic [8:0]      inst_in;
    logic            branch_cond;
    logic [4:0]      ptr_w;
    logic [4:0]      ptr_a;
    logic [7:0]      ptr_b;
    logic            const_flag;
    logic            we;
    logic [2:0]      alu_op;
    logic            busy;
    logic            done;
    logic [15:0]     instr_count;

    modport master (
        input  start, inst_in, branch_cond,
        output inst_addr, ptr_w, ptr_a, ptr_b, const_flag, we, alu_op,
               busy, done, instr_count
    );

    modport slave (
        output start, inst_in, branch_cond,
        input  inst_addr, ptr_w, ptr_a, ptr_b, const_flag, we, alu_op,
               busy, done, instr_count
    );
endinterface

// File: rtl/fetch_decode.sv
// Instruction fetch/decode stage: PC, IR, decode, relative branch and HALT handling.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | fetching one instruction per cycle, decoding the IR
//   DONE  | HALT retired, PC frozen, waiting for start
module fetch_decode #(
    parameter int PC_W = 10
) (
    input  logic          clk,
    input  logic          reset,
    fetch_decode_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic [8:0]      ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic            start_en_q;

    logic [2:0]      op, rd, rs;
    logic            dec_active, is_halt, is_bnz, taken, start_acc;
    logic [PC_W+5:0] off_ext;

    logic [4:0]      ptr_w, ptr_a;
    logic [7:0]      ptr_b;
    logic            const_flag, we;
    logic [2:0]      alu_op;

    assign op = ir_q[8:6];
    assign rd = ir_q[5:3];
    assign rs = ir_q[2:0];

    assign dec_active = ir_valid_q && (state_q == RUN);
    assign is_halt    = (op == 3'b111) && (ir_q[5:0] == 6'h3F);
    assign is_bnz     = (op == 3'b111) && !is_halt;
    assign taken      = dec_active && is_bnz && bus.branch_cond;
    assign off_ext    = {{PC_W{ir_q[5]}}, ir_q[5:0]};

    // start_en_q blocks a start seen on the very edge that releases reset
    assign start_acc  = (state_q != RUN) && bus.start && start_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_pc_q    <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            start_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_pc_q    <= ir_pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            start_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_pc_d    = ir_pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    state_d    = RUN;
                    pc_d       = '0;
                    ir_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (dec_active && is_halt) begin
                    state_d    = DONE;
                    ir_valid_d = 1'b0;
                end else if (taken) begin
                    // branch target is relative to the branch's own address
                    pc_d       = ir_pc_q + off_ext[PC_W-1:0];
                    ir_valid_d = 1'b0;
                end else begin
                    ir_d       = bus.inst_in;
                    ir_pc_d    = pc_q;
                    pc_d       = pc_q + PC_W'(1);
                    ir_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_w      = '0;
        ptr_a      = '0;
        ptr_b      = '0;
        const_flag = 1'b0;
        we         = 1'b0;
        alu_op     = '0;
        if (dec_active) begin
            alu_op = op;
            case (op)
                3'b000, 3'b001, 3'b010, 3'b011, 3'b100: begin
                    ptr_w = {2'b00, rd};
                    ptr_a = {2'b00, rd};
                    ptr_b = {5'b00000, rs};
                    we    = 1'b1;
                end
                3'b101: begin
                    ptr_w = {2'b00, rd};
                    ptr_b = {5'b00000, rs};
                    we    = 1'b1;
                end
                3'b110: begin
                    ptr_w      = {2'b00, rd};
                    ptr_b      = {5'b00000, rs};
                    const_flag = 1'b1;
                    we         = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.inst_addr  = pc_q;
    assign bus.ptr_w      = ptr_w;
    assign bus.ptr_a      = ptr_a;
    assign bus.ptr_b      = ptr_b;
    assign bus.const_flag = const_flag;
    assign bus.we         = we;
    assign bus.alu_op     = alu_op;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);

`ifdef INSTR_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (dec_active) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.instr_count = cnt_q;
`else
    assign bus.instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: ROM models, expected per-cycle outputs queued
// from the programmed instructions and compared at the falling edge.
module tb_fetch_decode;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_decode_if #(.PC_W(10)) bus ();
    fetch_decode_if #(.PC_W(4))  bus4 ();

    fetch_decode #(.PC_W(10)) dut  (.clk(clk), .reset(reset), .bus(bus));
    fetch_decode #(.PC_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

    logic [8:0] rom  [1024];
    logic [8:0] rom4 [16];
    assign bus.inst_in  = rom[bus.inst_addr];
    assign bus4.inst_in = rom4[bus4.inst_addr];

    int errors = 0;
    int checks = 0;
    logic [34:0] sb [$];
    logic [34:0] exp_v;
    logic [34:0] act_v;

`ifdef INSTR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [8:0] HALT = 9'h1FF;
    localparam logic [8:0] NOP  = 9'h140;

    function automatic logic [15:0] cnt_exp(input int n);
        return CNT_EN ? 16'(n) : 16'd0;
    endfunction

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
        return {op, rd, rs};
    endfunction

    function automatic logic [8:0] bnz(input logic [5:0] off);
        return {3'b111, off};
    endfunction

    // Reference decode: {busy, done, addr, we, const, alu_op, ptr_w, ptr_a, ptr_b}
    function automatic logic [34:0] model(input bit busy, input bit done, input logic [9:0] addr,
                                          input bit valid, input logic [8:0] ir);
        logic       w, cf;
        logic [2:0] o;
        logic [4:0] pw, pa;
        logic [7:0] pb;
        w = 1'b0; cf = 1'b0; o = 3'd0; pw = 5'd0; pa = 5'd0; pb = 8'd0;
        if (valid) begin
            o = ir[8:6];
            if (ir[8:6] <= 3'd4) begin
                w = 1'b1; pw = {2'b0, ir[5:3]}; pa = {2'b0, ir[5:3]}; pb = {5'b0, ir[2:0]};
            end else if (ir[8:6] == 3'd5) begin
                w = 1'b1; pw = {2'b0, ir[5:3]}; pb = {5'b0, ir[2:0]};
            end else if (ir[8:6] == 3'd6) begin
                w = 1'b1; cf = 1'b1; pw = {2'b0, ir[5:3]}; pb = {5'b0, ir[2:0]};
            end
        end
        return {busy, done, addr, w, cf, o, pw, pa, pb};
    endfunction

    function automatic logic [34:0] obs10();
        return {bus.busy, bus.done, bus.inst_addr, bus.we, bus.const_flag, bus.alu_op,
                bus.ptr_w, bus.ptr_a, bus.ptr_b};
    endfunction

    function automatic logic [34:0] obs4();
        return {bus4.busy, bus4.done, 6'b0, bus4.inst_addr, bus4.we, bus4.const_flag, bus4.alu_op,
                bus4.ptr_w, bus4.ptr_a, bus4.ptr_b};
    endfunction

    function automatic void sb_run(input int addr, input bit valid, input logic [8:0] ir);
        sb.push_back(model(1'b1, 1'b0, 10'(addr), valid, ir));
    endfunction

    function automatic void sb_done(input int addr);
        sb.push_back(model(1'b0, 1'b1, 10'(addr), 1'b0, 9'd0));
    endfunction

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = NOP;
        foreach (rom4[i]) rom4[i] = NOP;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.start = 1'b0;
        bus4.start = 1'b0;
        bus.branch_cond = 1'b0;
        bus4.branch_cond = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        reset = 1'b0;
        bus.start = 1'b0;
        bus4.start = 1'b0;
        bus.branch_cond = 1'b0;
        bus4.branch_cond = 1'b0;
        #1;
        checks++;
        if (obs10() !== 35'd0 || bus.instr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h, expected 0/0", obs10(), bus.instr_count);
        end
        checks++;
        if (obs4() !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs4: got %h, expected 0", obs4());
        end
        // release reset just before an edge with start already high
        @(negedge clk);
        #4 reset = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        checks++;
        if (obs10() !== 35'd0) begin
            errors++;
            $display("FAIL start_at_release: got %h, expected %h", obs10(), 35'd0);
        end
        @(negedge clk);
        exp_v = model(1'b1, 1'b0, 10'd0, 1'b0, 9'd0);
        checks++;
        if (obs10() !== exp_v) begin
            errors++;
            $display("FAIL start_next_edge: got %h, expected %h", obs10(), exp_v);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_sequential();
        int cyc;
        apply_reset();
        clear_rom();
        rom[0] = enc(3'd0, 3'd1, 3'd2);
        rom[1] = enc(3'd6, 3'd3, 3'd5);
        rom[2] = HALT;
        sb_run(0, 0, 9'd0);
        sb_run(1, 1, rom[0]);
        sb_run(2, 1, rom[1]);
        sb_run(3, 1, rom[2]);
        sb_done(3);
        do_start();
        cyc = 1;
        while (sb.size() != 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            act_v = obs10();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL sequential cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
            end
            cyc++;
        end
        checks++;
        if (bus.instr_count !== cnt_exp(3)) begin
            errors++;
            $display("FAIL sequential_count: got %0d, expected %0d", bus.instr_count, cnt_exp(3));
        end
    endtask

    task automatic test_branch();
        int cyc;
        apply_reset();
        clear_rom();
        rom[0] = enc(3'd5, 3'd1, 3'd0);
        rom[1] = enc(3'd1, 3'd2, 3'd3);
        rom[2] = enc(3'd2, 3'd4, 3'd5);
        rom[3] = enc(3'd3, 3'd6, 3'd7);
        rom[4] = bnz(6'h3E);
        rom[5] = enc(3'd4, 3'd7, 3'd1);
        rom[6] = HALT;
        sb_run(0, 0, 9'd0);
        sb_run(1, 1, rom[0]);
        sb_run(2, 1, rom[1]);
        sb_run(3, 1, rom[2]);
        sb_run(4, 1, rom[3]);
        sb_run(5, 1, rom[4]);
        sb_run(2, 0, 9'd0);
        sb_run(3, 1, rom[2]);
        sb_run(4, 1, rom[3]);
        sb_run(5, 1, rom[4]);
        sb_run(6, 1, rom[5]);
        sb_run(7, 1, rom[6]);
        sb_done(7);
        do_start();
        cyc = 1;
        while (sb.size() != 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            act_v = obs10();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL branch cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
            end
            bus.branch_cond = (cyc == 6);
            cyc++;
        end
        checks++;
        if (bus.instr_count !== cnt_exp(10)) begin
            errors++;
            $display("FAIL branch_count: got %0d, expected %0d", bus.instr_count, cnt_exp(10));
        end
    endtask

    task automatic test_halt();
        int cyc;
        apply_reset();
        clear_rom();
        rom[0] = enc(3'd6, 3'd1, 3'd7);
        rom[1] = enc(3'd0, 3'd2, 3'd1);
        rom[2] = enc(3'd5, 3'd3, 3'd2);
        rom[3] = HALT;
        rom[4] = enc(3'd0, 3'd7, 3'd7);
        sb_run(0, 0, 9'd0);
        sb_run(1, 1, rom[0]);
        sb_run(2, 1, rom[1]);
        sb_run(3, 1, rom[2]);
        sb_run(4, 1, rom[3]);
        sb_done(4);
        sb_done(4);
        sb_done(4);
        do_start();
        cyc = 1;
        while (sb.size() != 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            act_v = obs10();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL halt cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
            end
            cyc++;
        end
        checks++;
        if (bus.instr_count !== cnt_exp(4)) begin
            errors++;
            $display("FAIL halt_count: got %0d, expected %0d", bus.instr_count, cnt_exp(4));
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        apply_reset();
        clear_rom();
        for (int i = 0; i < 6; i++) rom[i] = enc(3'(i % 5), 3'(i), 3'(7 - i));
        rom[6] = HALT;
        sb_run(0, 0, 9'd0);
        for (int k = 2; k <= 8; k++) sb_run(k - 1, 1, rom[k - 2]);
        sb_done(7);
        do_start();
        cyc = 1;
        while (sb.size() != 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            act_v = obs10();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL start_in_run cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
            end
            bus.start = (cyc == 3 || cyc == 4);
            cyc++;
        end
        // restart from DONE clears the count and fetches from 0 again
        do_start();
        sb_run(0, 0, 9'd0);
        sb_run(1, 1, rom[0]);
        cyc = 1;
        while (sb.size() != 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            act_v = obs10();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL restart cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
            end
            if (cyc == 1) begin
                checks++;
                if (bus.instr_count !== 16'd0) begin
                    errors++;
                    $display("FAIL restart_count: got %0d, expected 0", bus.instr_count);
                end
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        apply_reset();
        clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = enc(3'd6, 3'(i), 3'(i + 2));
        sb_run(0, 0, 9'd0);
        for (int k = 2; k <= 5; k++) sb_run(k - 1, 1, rom[k - 2]);
        do_start();
        cyc = 1;
        while (sb.size() != 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            act_v = obs10();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL pre_reset cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
            end
            cyc++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs10() !== 35'd0 || bus.instr_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h/%h, expected 0/0", obs10(), bus.instr_count);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs10() !== 35'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h, expected 0", obs10());
        end
        sb_run(0, 0, 9'd0);
        sb_run(1, 1, rom[0]);
        sb_run(2, 1, rom[1]);
        do_start();
        cyc = 1;
        while (sb.size() != 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            act_v = obs10();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL post_reset_run cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic test_wrap();
        int cyc;
        apply_reset();
        clear_rom();
        for (int i = 0; i < 16; i++) rom4[i] = enc(3'd6, 3'(i), 3'(i + 1));
        rom4[0]  = enc(3'd0, 3'd1, 3'd2);
        rom4[15] = enc(3'd5, 3'd0, 3'd0);
        sb_run(0, 0, 9'd0);
        for (int k = 2; k <= 19; k++) sb_run((k - 1) % 16, 1, rom4[(k - 2) % 16]);
        @(negedge clk);
        bus4.start = 1'b1;
        @(posedge clk);
        #1 bus4.start = 1'b0;
        cyc = 1;
        while (sb.size() != 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            act_v = obs4();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL wrap cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
            end
            cyc++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus4.start = 1'b0;
        bus.branch_cond = 1'b0;
        bus4.branch_cond = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_halt();
        test_start_ignored();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode stage directly upstream of the 8-bit register file. It holds the program counter, drives the instruction ROM address, and latches the 9-bit instruction into an instruction register (IR). It decodes the IR into register-file pointers, the constant flag, the write enable and the ALU opcode. It also resolves relative branches and a HALT instruction, and runs a start/done handshake with the testbench or top level.

## Interface
- PC_W, 10 — program counter / instruction address width
- clk  in  1  — single clock, all state on rising edge
- reset  in  1  — asynchronous, active-low; clears all state
- start  in  1  — level sampled on rising edge; begins execution at PC 0 when in IDLE or DONE
- inst_addr  out  PC_W  — ROM address, equals PC
- inst_in  in  9  — ROM data for inst_addr, combinational, same cycle
- branch_cond  in  1  — ALU condition flag, sampled in the cycle a branch sits in IR
- ptr_w  out  5  — register-file write pointer
- ptr_a  out  5  — register-file A read pointer
- ptr_b  out  8  — register-file B pointer, or zero-extended constant when const_flag=1
- const_flag  out  1  — ptr_b carries a constant
- we  out  1  — register-file write enable
- alu_op  out  3  — ALU operation, equals IR[8:6]
- busy  out  1  — state is RUN
- done  out  1  — state is DONE
- instr_count  out  16  — retired-instruction count (see Configuration)

## Operation
- States: IDLE (after reset), RUN, DONE.
  - IDLE/DONE → RUN on start=1: PC←0, ir_valid←0, done←0.
  - RUN ignores start.
  - RUN → DONE when a valid IR holds HALT.
- In RUN, every cycle: IR←inst_in, ir_pc←PC, PC←PC+1 (wraps modulo 2^PC_W), ir_valid←1, unless a branch is taken or HALT is decoded.
- Decode applies only when ir_valid=1 and state=RUN. Otherwise all pointer outputs are 0 and we, const_flag and alu_op are 0.
- Field layout: op=IR[8:6], rd=IR[5:3], rs=IR[2:0]. All pointers are zero-extended.
  - op 000–100 (ADD, SUB, AND, XOR, SHL): ptr_w=ptr_a=rd, ptr_b=rs, const_flag=0, we=1.
  - op 101 MOV: ptr_w=rd, ptr_a=0, ptr_b=rs, we=1.
  - op 110 LDI: ptr_w=rd, ptr_a=0, ptr_b=rs as constant, const_flag=1, we=1.
  - op 111 with IR[5:0]=6'h3F: HALT, we=0.
  - op 111 otherwise: BNZ with signed 6-bit offset IR[5:0], we=0, ptr_a=ptr_b=ptr_w=0.
- BNZ taken (branch_cond=1):
  - PC←ir_pc+sext(offset), modulo 2^PC_W.
  - ir_valid←0, which discards the instruction fetched in the same cycle.
- BNZ not taken: continues sequentially, no bubble.
- HALT: state←DONE, ir_valid←0, PC holds. The fetched successor is discarded.
- Reset at any time: state IDLE, PC 0, IR 0, ir_valid 0, instr_count 0. All outputs 0.

## Timing
- Start accepted at edge E0. During cycle 1, inst_addr=0. IR holds instruction 0 during cycle 2, with decoded outputs valid in that cycle; the register file writes at edge E2.
- Fetch-to-decode latency 1 cycle; throughput 1 instruction/cycle.
- Taken branch costs exactly 1 bubble cycle (we=0). The target instruction decodes 2 cycles after the branch decodes.
- HALT in IR at cycle n: done=1 and busy=0 from cycle n+1, held until the next start.
- start=1 on the same edge as reset deassertion is ignored; the first start is sampled at the next edge.

## Configuration
- INSTR_COUNT_EN defined:
  - 16-bit counter increments on each cycle with ir_valid=1 in RUN, including HALT and branches.
  - Clears on start, wraps at 0xFFFF.
- INSTR_COUNT_EN undefined: no counter logic; instr_count tied to 0.

## Test plan
- Sequential program: program ADD r1,r2 at 0 and LDI r3,#5 at 1, then pulse start. Cycle 2: ptr_w=1, ptr_a=1, ptr_b=2, we=1, alu_op=0. Cycle 3: ptr_w=3, ptr_a=0, ptr_b=5, const_flag=1.
- Taken branch: BNZ −2 at address 4 with branch_cond=1. inst_addr becomes 2, 1 bubble cycle with we=0, then address-2 instruction decodes. With branch_cond=0, address 5 follows without bubble.
- HALT: HALT at 3. done=1 the cycle after it decodes, busy=0, and we stays 0. Address 4 never decodes. With INSTR_COUNT_EN, instr_count=4.
- Wrap: PC_W=4 with a NOP-like MOV r0,r0 at 15. inst_addr goes 15→0.
- Reset mid-run: assert reset during cycle 5 of a program. All outputs are 0 immediately, state is IDLE, and start restarts at address 0.
- Start ignored while busy: pulse start in RUN. PC sequence is unaffected.
